// File: rtl/ieee_norm_pack_if.sv
// Handshake and data bundle for the IEEE single-precision normalize/round/pack back-end.
// The master side feeds raw adder results and consumes packed words; the slave side is the block.
interface ieee_norm_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_zero;
  logic        flag_overflow;
  logic        flag_underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_overflow, flag_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_overflow, flag_underflow
  );
endinterface

// File: rtl/ieee_norm_pack.sv
// Normalizes a raw adder result one bit per cycle, rounds (RNE) and packs it into an IEEE-754 word.
// Define IEEE_NORM_PACK_ROUND_EN to include the ROUND state; otherwise the fraction is truncated.
module ieee_norm_pack (
  input  logic            clk,
  input  logic            rst,
  ieee_norm_pack_if.slave bus
);

`ifdef IEEE_NORM_PACK_ROUND_EN
  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t             state, state_n;
  logic               sign_q, sign_n;
  logic signed [9:0]  exp_q, exp_n;
  logic [26:0]        mant_q, mant_n;
  logic               special_q, special_n;
  logic [31:0]        result_q, result_n;
  logic               zero_q, zero_n;
  logic               ovf_q, ovf_n;
  logic               unf_q, unf_n;
  logic               accept;

  // Returns {overflow, word}; exponents at or above 255 saturate to signed infinity.
  function automatic logic [32:0] pack_word(input logic s, input logic signed [9:0] e,
                                            input logic [22:0] f);
    if (e >= 10'sd255) return {1'b1, s, 8'hFF, 23'h0};
    else               return {1'b0, s, e[7:0], f};
  endfunction

`ifdef IEEE_NORM_PACK_ROUND_EN
  logic        rnd_inc;
  logic [24:0] rnd_sum;
  assign rnd_inc = mant_q[1] & (mant_q[0] | mant_q[2]);
  assign rnd_sum = mant_q[26:2] + {24'h0, rnd_inc};
`endif

  assign bus.in_ready       = (state == IDLE) && !rst;
  assign bus.out_valid      = (state == DONE);
  assign bus.result         = result_q;
  assign bus.flag_zero      = zero_q;
  assign bus.flag_overflow  = ovf_q;
  assign bus.flag_underflow = unf_q;
  assign accept             = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      special_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state     <= state_n;
      sign_q    <= sign_n;
      exp_q     <= exp_n;
      mant_q    <= mant_n;
      special_q <= special_n;
      result_q  <= result_n;
      zero_q    <= zero_n;
      ovf_q     <= ovf_n;
      unf_q     <= unf_n;
    end
  end

  always_comb begin
    state_n   = state;
    sign_n    = sign_q;
    exp_n     = exp_q;
    mant_n    = mant_q;
    special_n = special_q;
    result_n  = result_q;
    zero_n    = zero_q;
    ovf_n     = ovf_q;
    unf_n     = unf_q;
    case (state)
      IDLE: begin
        if (accept) begin
          sign_n    = bus.in_sign;
          exp_n     = {2'b00, bus.in_exp};
          mant_n    = bus.in_mant;
          special_n = &bus.in_exp;
          zero_n    = 1'b0;
          ovf_n     = 1'b0;
          unf_n     = 1'b0;
          state_n   = NORM;
        end
      end
      NORM: begin
        // exp==255 is latched at accept so a carry that reaches 255 still overflows.
        if (special_q) begin
          result_n = (mant_q[24:2] == '0) ? {sign_q, 8'hFF, 23'h0} : 32'h7FC0_0000;
          state_n  = DONE;
        end else if (mant_q == '0) begin
          result_n = {sign_q, 31'h0};
          zero_n   = 1'b1;
          state_n  = DONE;
        end else if (mant_q[26]) begin
          mant_n = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
          exp_n  = exp_q + 10'sd1;
        end else if (!mant_q[25] && (exp_q > 10'sd1)) begin
          mant_n = {mant_q[25:0], 1'b0};
          exp_n  = exp_q - 10'sd1;
        end else if (!mant_q[25]) begin
          result_n = {sign_q, 31'h0};
          zero_n   = 1'b1;
          unf_n    = 1'b1;
          state_n  = DONE;
        end else begin
`ifdef IEEE_NORM_PACK_ROUND_EN
          state_n = ROUND;
`else
          {ovf_n, result_n} = pack_word(sign_q, exp_q, mant_q[24:2]);
          state_n           = DONE;
`endif
        end
      end
`ifdef IEEE_NORM_PACK_ROUND_EN
      ROUND: begin
        if (rnd_sum[24]) {ovf_n, result_n} = pack_word(sign_q, exp_q + 10'sd1, rnd_sum[23:1]);
        else             {ovf_n, result_n} = pack_word(sign_q, exp_q, rnd_sum[22:0]);
        state_n = DONE;
      end
`endif
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ieee_norm_pack.sv
// Directed-vector bench for ieee_norm_pack: results, flags, latency, backpressure and reset.
module tb_ieee_norm_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ieee_norm_pack_if bus ();

  ieee_norm_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef IEEE_NORM_PACK_ROUND_EN
  localparam int          RL      = 1;
  localparam logic [31:0] E_RNE   = 32'h4000_0000;
  localparam logic [31:0] E_ODD   = 32'h3F80_0002;
  localparam logic [31:0] E_STK   = 32'h3F80_0001;
  localparam logic [31:0] E_SHSTK = 32'h4000_0001;
`else
  localparam int          RL      = 0;
  localparam logic [31:0] E_RNE   = 32'h3FFF_FFFF;
  localparam logic [31:0] E_ODD   = 32'h3F80_0001;
  localparam logic [31:0] E_STK   = 32'h3F80_0000;
  localparam logic [31:0] E_SHSTK = 32'h4000_0000;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Flags are ordered {zero, overflow, underflow}.
  task automatic run(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                     input logic [31:0] er, input logic [2:0] ef, input int el, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sign  = ~s;
    bus.in_exp   = 8'h55;
    bus.in_mant  = '1;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(el));
    check({tag, "_res"}, 64'(bus.result), 64'(er));
    check({tag, "_flg"}, 64'({bus.flag_zero, bus.flag_overflow, bus.flag_underflow}), 64'(ef));
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {30'h0, bus.out_valid, bus.in_ready, bus.result},
              {30'h0, 1'b1, 1'b0, er});
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_ack"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 64'(bus.in_ready), 64'd0);
    check("rst_vld", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst", {29'h0, bus.in_ready, bus.out_valid, bus.flag_zero, bus.flag_overflow,
                       bus.flag_underflow, bus.result}, {29'h0, 5'b10000, 32'h0});

    run("one",    1'b0, 8'd127, 27'h2000000, 32'h3F80_0000, 3'b000, 1 + RL,  0);
    run("neg",    1'b1, 8'd127, 27'h2000000, 32'hBF80_0000, 3'b000, 1 + RL,  0);
    run("carry",  1'b0, 8'd127, 27'h4000000, 32'h4000_0000, 3'b000, 2 + RL,  0);
    run("cancel", 1'b0, 8'd127, 27'h0000004, 32'h3400_0000, 3'b000, 24 + RL, 0);
    run("rne",    1'b0, 8'd127, 27'h3FFFFFE, E_RNE,         3'b000, 1 + RL,  0);
    run("tie_ev", 1'b0, 8'd127, 27'h2000002, 32'h3F80_0000, 3'b000, 1 + RL,  0);
    run("tie_od", 1'b0, 8'd127, 27'h2000006, E_ODD,         3'b000, 1 + RL,  0);
    run("sticky", 1'b0, 8'd127, 27'h2000003, E_STK,         3'b000, 1 + RL,  0);
    run("shstk",  1'b0, 8'd127, 27'h4000006, E_SHSTK,       3'b000, 2 + RL,  0);
    run("ovf",    1'b0, 8'd254, 27'h4000000, 32'h7F80_0000, 3'b010, 2 + RL,  0);
    run("zero",   1'b1, 8'd100, 27'h0000000, 32'h8000_0000, 3'b100, 1,       0);
    run("unf",    1'b0, 8'd1,   27'h1000000, 32'h0000_0000, 3'b101, 1,       0);
    run("inf",    1'b1, 8'd255, 27'h2000000, 32'hFF80_0000, 3'b000, 1,       0);
    run("nan",    1'b0, 8'd255, 27'h0000100, 32'h7FC0_0000, 3'b000, 1,       0);
    run("bp",     1'b0, 8'd128, 27'h2000000, 32'h4000_0000, 3'b000, 1 + RL,  10);

    // Reset in the middle of a long left-shift sequence must discard the result.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 8'd127;
    bus.in_mant  = 27'h0000004;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst", 64'({bus.out_valid, bus.in_ready}), 64'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("mid_drop", 64'(seen), 64'd0);
    run("recov", 1'b0, 8'd127, 27'h4000000, 32'h4000_0000, 3'b000, 2 + RL, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/ieee_norm_pack.md
# ieee_norm_pack

Result back-end for the IEEE-754 single-precision adder datapath. It accepts a raw, unnormalized adder result (sign, biased exponent, 27-bit extended mantissa) and normalizes it with a one-bit-per-cycle shift FSM. It then rounds to nearest-even and packs the value into a 32-bit IEEE word with status flags. It sits between the add/subtract core and any consumer of packed IEEE operands, the inverse of the core's packed-in/unpacked-out boundary.

## Interface
- No parameters; widths are fixed to IEEE single precision.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  raw result present.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `in_sign`  in  1  result sign.
- `in_exp`  in  8  biased exponent of the value `in_mant[25]` position.
- `in_mant`  in  27  `[26]` carry-out, `[25]` integer bit, `[24:2]` fraction, `[1]` guard, `[0]` sticky.
- `out_valid`  out  1  `result` and flags valid; held until accepted.
- `out_ready`  in  1  consumer accepts.
- `result`  out  32  packed IEEE word {sign, exp[7:0], frac[22:0]}.
- `flag_zero`, `flag_overflow`, `flag_underflow`  out  1 each  status, valid with `out_valid`.

## Operation
- States: IDLE, NORM, ROUND, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, capture the sign, the exponent into a 10-bit signed internal register, and the mantissa. Go to NORM.
- Special input `in_exp`==255 goes directly to DONE:
  - fraction `[24:2]`==0: ±infinity.
  - otherwise: quiet NaN 0x7FC00000.
  - Flags 0.
- NORM executes one action per cycle, in this priority:
  - mant==0: result ±0 using the captured sign, `flag_zero`=1, go to DONE.
  - `mant[26]`=1: shift right 1, `mant[0]` |= shifted-out bit (sticky preserved), exp+1.
  - `mant[25]`=0 and exp>1: shift left 1, exp−1.
  - `mant[25]`=0 and exp≤1: flush to ±0, `flag_underflow`=1, `flag_zero`=1, go to DONE. Denormals are not produced.
  - `mant[25]`=1 and `mant[26]`=0: normalized, go to ROUND.
- ROUND (round-to-nearest-even):
  - Increment `mant[26:2]` when guard & (sticky | `mant[2]`).
  - If the increment carries into bit 26, shift right 1 and exp+1 in the same cycle.
  - Then: exp≥255 gives ±infinity (0x7F800000 | sign) with `flag_overflow`=1. Exp≤0 cannot occur here.
  - Otherwise pack {sign, exp[7:0], `mant[24:2]`}. Go to DONE.
- DONE: `out_valid`=1. `result` and the flags are stable until `out_valid && out_ready`, then go to IDLE. There is no bypass: a new input is accepted at the earliest one cycle after the handshake.

## Timing
- Reset values: state IDLE, `in_ready`=1 (from the cycle after reset deasserts; 0 while `rst`=1), `out_valid`=0, `result`=0, all flags 0.
- Latency is measured from the accept edge to the first cycle with `out_valid`=1, with k = number of NORM shift steps (0..25):
  - Normal path: 2 + k cycles.
  - Zero/underflow path: 1 + k cycles.
  - exp==255 path: 1 cycle.
- Worst case: a single fraction LSB after cancellation takes 23 left shifts.
- Backpressure: with `out_ready`=0, DONE holds indefinitely and `in_ready` stays 0.
- `rst` asserted in any state returns to IDLE on that edge and discards the in-flight result. `out_valid` is 0 in the following cycle.
- Inputs are sampled only on the accept edge; changes to `in_*` at any other time have no effect.

## Configuration
- `IEEE_NORM_PACK_ROUND_EN` defined: ROUND state present, RNE as above.
- Not defined: guard and sticky are ignored (truncation) and ROUND is removed. NORM goes straight to DONE when normalized, packing directly and applying the overflow check there. Normal-path latency becomes 1 + k cycles.

## Test plan
- sign 0, exp 127, mant 27'h2000000 -> `result` 0x3F800000, flags 0, latency 2.
- sign 0, exp 127, mant 27'h4000000 (carry) -> 0x40000000, latency 3.
- sign 0, exp 127, mant 27'h0000004 (cancellation of near-equal operands) -> 23 left shifts, 0x34000000, latency 25.
- sign 0, exp 127, mant 27'h3FFFFFE (all-ones fraction, guard 1, sticky 0):
  - with `IEEE_NORM_PACK_ROUND_EN`: -> 0x40000000.
  - without the macro: -> 0x3FFFFFFF.
- Special values:
  - sign 0, exp 254, mant 27'h4000000 -> 0x7F800000, `flag_overflow`=1.
  - sign 1, mant 0 -> 0x80000000, `flag_zero`=1.
  - exp 1, mant 27'h1000000 -> flush to 0x00000000, `flag_underflow`=1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 10 cycles: `result` stable, `in_ready`=0; accepted on the first `out_ready`.
  - Assert `rst` mid-NORM: IDLE next cycle, `out_valid` stays 0.
